// File: rtl/spi_slave_byte_tx_if.sv
// ---------------------------------------------------------------------------
// spi_slave_byte_tx_if
//
// Signal bundle between the SPI slave byte transmitter, its upstream byte
// source and the external SPI pins.
//
//   data_in      upstream -> slave   byte to transmit (stable LOAD_DLY cycles
//                                    after spi_rd until the next spi_rd)
//   spi_rd       slave -> upstream   one-cycle "byte done, advance" pulse
//   spi_sck      pin -> slave        SPI clock from the master (asynchronous)
//   spi_cs_n     pin -> slave        chip select, active low (asynchronous)
//   spi_miso     slave -> pin        serial data, MSB first
//   spi_miso_oe  slave -> pin        MISO output enable
//   busy         slave -> system     frame in progress
//   overrun      slave -> system     sticky: SCK edge arrived before reload
//   byte_cnt     slave -> system     bytes completed in the current frame
//
// Modports:
//   slave   - the transmitter itself
//   master  - everything around it (upstream stage, SPI master, monitor)
// ---------------------------------------------------------------------------
interface spi_slave_byte_tx_if #(
    parameter int CNT_W = 17
);
    logic [7:0]       data_in;
    logic             spi_rd;
    logic             spi_sck;
    logic             spi_cs_n;
    logic             spi_miso;
    logic             spi_miso_oe;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] byte_cnt;

    modport slave (
        input  data_in,
        input  spi_sck,
        input  spi_cs_n,
        output spi_rd,
        output spi_miso,
        output spi_miso_oe,
        output busy,
        output overrun,
        output byte_cnt
    );

    modport master (
        output data_in,
        output spi_sck,
        output spi_cs_n,
        input  spi_rd,
        input  spi_miso,
        input  spi_miso_oe,
        input  busy,
        input  overrun,
        input  byte_cnt
    );
endinterface

// File: rtl/spi_slave_byte_tx.sv
// ---------------------------------------------------------------------------
// spi_slave_byte_tx
//
// SPI mode-0 slave transmitter, MSB first. Sits between the JPEG-to-SPI glue
// stage and the ESP32 SPI master. The byte on bus.data_in is loaded into a
// shift register and presented bit by bit on bus.spi_miso; after the eighth
// SCK cycle bus.spi_rd pulses for one clk so the upstream stage advances.
//
// SCK and CS_N are oversampled in the clk domain; nothing is clocked by SCK.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    spi_slave_byte_tx_if.slave (see interface header for signals)
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for spi_sck / spi_cs_n (>= 2)
//   LOAD_DLY     clk cycles from the spi_rd pulse to sampling data_in
//   CNT_W        width of byte_cnt
// ---------------------------------------------------------------------------
module spi_slave_byte_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int LOAD_DLY    = 3,
    parameter int CNT_W       = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_byte_tx_if.slave    bus
);

    // -----------------------------------------------------------------------
    // Local parameters and types
    // -----------------------------------------------------------------------
    localparam int DLY_W = (LOAD_DLY > 1) ? $clog2(LOAD_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(LOAD_DLY - 1);

    // Idle level of each synchronised pin: bit 1 = spi_cs_n (high),
    // bit 0 = spi_sck (low, mode 0).
    localparam logic [1:0] SYNC_RST = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADV    = 2'd2,
        RELOAD = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -----------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_sync;
    logic [1:0] w_hist;

    assign w_raw = {bus.spi_cs_n, bus.spi_sck};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            logic                   r_hist;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_chain <= {SYNC_STAGES{SYNC_RST[gi]}};
                    r_hist  <= SYNC_RST[gi];
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_raw[gi]};
                    r_hist  <= r_chain[SYNC_STAGES-1];
                end
            end

            assign w_sync[gi] = r_chain[SYNC_STAGES-1];
            assign w_hist[gi] = r_hist;
        end
    endgenerate

    // The CS synchroniser comes out of reset holding "deasserted". If the pin
    // is already low when reset is released, the first real samples would
    // look like a falling edge. r_cs_fill tracks which stages (plus history)
    // hold genuine samples; CS edges are only believed once the whole chain
    // has been refilled, so a frame only starts on a fresh CS falling edge.
    logic [SYNC_STAGES:0] r_cs_fill;
    logic                 w_cs_live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_fill <= '0;
        end else begin
            r_cs_fill <= {r_cs_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_cs_live = r_cs_fill[SYNC_STAGES];

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sck_rise = w_sync[0] & ~w_hist[0];
    assign w_sck_fall = ~w_sync[0] & w_hist[0];
    assign w_cs_fall  = w_cs_live & w_hist[1] & ~w_sync[1];
    assign w_cs_rise  = w_cs_live & ~w_hist[1] & w_sync[1];

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_next;
    logic [3:0]       r_bit_cnt;
    logic [3:0]       w_bit_cnt_next;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] w_byte_cnt_next;
    logic             r_overrun;
    logic             w_overrun_next;
    logic [DLY_W-1:0] r_dly;
    logic [DLY_W-1:0] w_dly_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_overrun  <= 1'b0;
            r_dly      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_shreg    <= w_shreg_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_overrun  <= w_overrun_next;
            r_dly      <= w_dly_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_shreg_next    = r_shreg;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_cnt_next = r_byte_cnt;
        w_overrun_next  = r_overrun;
        w_dly_next      = r_dly;

        case (r_state)
            IDLE: begin
                // SCK edges are meaningless outside a frame; only CS falling
                // starts work, and it wins over any coincident SCK edge.
                if (w_cs_fall) begin
                    w_shreg_next    = bus.data_in;
                    w_bit_cnt_next  = '0;
                    w_byte_cnt_next = '0;
                    w_overrun_next  = 1'b0;
                    w_state_next    = SHIFT;
                end
            end

            SHIFT: begin
                if (w_cs_rise) begin
                    // Partial byte is dropped; upstream was never advanced,
                    // so the same byte leads the next frame.
                    w_state_next = IDLE;
                end else if (w_sck_rise) begin
                    if (r_bit_cnt != 4'd8) begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end else if (w_sck_fall) begin
                    if (r_bit_cnt == 4'd8) begin
                        // Master has sampled all eight bits: no further shift.
                        w_state_next = ADV;
                    end else if (r_bit_cnt != 4'd0) begin
                        w_shreg_next = {r_shreg[6:0], 1'b0};
                    end
                end
            end

            ADV: begin
                w_byte_cnt_next = r_byte_cnt + CNT_W'(1);
                w_dly_next      = DLY_INIT;
                if (w_sck_rise) begin
                    w_overrun_next = 1'b1;
                end
                // The spi_rd pulse for this cycle completes regardless.
                w_state_next = w_cs_rise ? IDLE : RELOAD;
            end

            RELOAD: begin
                if (w_sck_rise) begin
                    w_overrun_next = 1'b1;
                end
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                end else if (r_dly == '0) begin
                    // Upstream has had LOAD_DLY cycles to present its byte.
                    w_shreg_next   = bus.data_in;
                    w_bit_cnt_next = '0;
                    w_state_next   = SHIFT;
                end else begin
                    w_dly_next = r_dly - DLY_W'(1);
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic w_active;

    assign w_active        = (r_state != IDLE);
    assign bus.busy        = w_active;
    assign bus.spi_miso_oe = w_active;
    assign bus.spi_miso    = w_active & r_shreg[7];
    assign bus.spi_rd      = (r_state == ADV);
    assign bus.overrun     = r_overrun;
    assign bus.byte_cnt    = r_byte_cnt;

endmodule

// File: tb/tb_spi_slave_byte_tx.sv
module tb_spi_slave_byte_tx;

    localparam int SYNC_STAGES = 2;
    localparam int LOAD_DLY    = 3;
    localparam int CNT_W       = 17;

    logic clk = 1'b0;
    logic reset;

    spi_slave_byte_tx_if #(.CNT_W(CNT_W)) bus ();

    spi_slave_byte_tx #(
        .SYNC_STAGES(SYNC_STAGES),
        .LOAD_DLY   (LOAD_DLY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Upstream byte source: presents the next byte 2 cycles after spi_rd
    // ------------------------------------------------------------------
    logic [7:0] up_q [0:255];
    int         up_idx   = 0;
    bit         up_ready = 0;

    initial begin
        wait (up_ready);
        bus.data_in = up_q[0];
        forever begin
            @(posedge clk);
            #1;
            if (bus.spi_rd === 1'b1) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                up_idx      = (up_idx + 1) % 256;
                bus.data_in = up_q[up_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the pin-level model of frame activity:
    // a frame is active some cycles after a fresh CS fall and idle some
    // cycles after CS rise; idle means no OE, no MISO, no spi_rd.
    // ------------------------------------------------------------------
    int hi_run = 0, lo_run = 0, cyc = 0, last_rd = -1000;
    bit armed = 0, frame_ok = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("oe_eq_busy", bus.spi_miso_oe, bus.busy);
            if (reset === 1'b1) begin
                hi_run = 0; lo_run = 0; armed = 0; frame_ok = 0;
                check("rst_busy", bus.busy, 0);
                check("rst_miso", bus.spi_miso, 0);
                check("rst_rd", bus.spi_rd, 0);
                check("rst_overrun", bus.overrun, 0);
                check("rst_byte_cnt", bus.byte_cnt, 0);
            end else begin
                if (bus.spi_cs_n) begin
                    hi_run++;
                    lo_run = 0;
                    if (hi_run >= SYNC_STAGES + 3) armed = 1;
                end else begin
                    if (lo_run == 0) frame_ok = armed;
                    lo_run++;
                    hi_run = 0;
                end
                if ((bus.spi_cs_n && hi_run > SYNC_STAGES + 2) || (!bus.spi_cs_n && !frame_ok)) begin
                    check("idle_busy", bus.busy, 0);
                    check("idle_miso", bus.spi_miso, 0);
                    check("idle_rd", bus.spi_rd, 0);
                end else if (!bus.spi_cs_n && frame_ok && lo_run > SYNC_STAGES + 2) begin
                    check("frame_busy", bus.busy, 1);
                end
                if (bus.spi_rd === 1'b1) begin
                    check("rd_spacing_ok", (cyc - last_rd > LOAD_DLY + 1) ? 1 : 0, 1);
                    last_rd = cyc;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SPI master + byte model: every 8 complete SCK cycles the master must
    // have received the next upstream byte (model index m_idx), and exactly
    // one spi_rd must follow the 8th falling edge.
    // ------------------------------------------------------------------
    int m_idx   = 0;
    int frame_n = 0;

    task automatic frame(input int nbits, input int hp, input bit chk,
                         output logic [7:0] first_rx, output logic [7:0] last_rx);
        logic [7:0] sh;
        int nrd, lat;
        sh = 8'h00;
        first_rx = 8'h00;
        last_rx  = 8'h00;
        bus.spi_cs_n = 1'b0;
        wait_clks(hp);
        for (int b = 0; b < nbits; b++) begin
            sh = {sh[6:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            wait_clks(hp);
            bus.spi_sck = 1'b0;
            nrd = 0;
            lat = 0;
            for (int c = 1; c <= hp; c++) begin
                wait_clks(1);
                if (bus.spi_rd === 1'b1) begin
                    nrd++;
                    if (lat == 0) lat = c;
                end
            end
            if (chk) begin
                if (b % 8 == 7) begin
                    check("rx_byte", sh, up_q[m_idx]);
                    check("rd_pulses", nrd, 1);
                    check("rd_latency_ok", (lat >= 1 && lat <= SYNC_STAGES + 3) ? 1 : 0, 1);
                    if (b == 7) first_rx = sh;
                    last_rx = sh;
                    m_idx = (m_idx + 1) % 256;
                end else begin
                    check("rd_pulses", nrd, 0);
                end
            end
        end
        bus.spi_cs_n = 1'b1;
        wait_clks(hp + 8);
        if (chk) begin
            check("byte_cnt", bus.byte_cnt, (nbits / 8) % (1 << CNT_W));
            check("overrun", bus.overrun, 0);
        end
        $display("frame %0d: bits=%0d hp=%0d first=%02h last=%02h byte_cnt=%0d overrun=%0b",
                 frame_n, nbits, hp, first_rx, last_rx, bus.byte_cnt, bus.overrun);
        frame_n++;
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] f, l;
        int nb, hp, nrd;

        reset        = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        up_q[0] = 8'hA5;
        up_q[1] = 8'hFF;
        up_q[2] = 8'hD9;
        up_q[3] = 8'h3C;
        for (int i = 4; i < 256; i++) up_q[i] = 8'($urandom_range(0, 255));
        up_ready = 1;
        wait_clks(4);
        check("reset_busy", bus.busy, 0);
        check("reset_miso", bus.spi_miso, 0);
        check("reset_byte_cnt", bus.byte_cnt, 0);
        reset = 1'b0;
        wait_clks(20);

        // Single byte A5
        frame(8, 10, 1, f, l);
        check("lit_A5", f, 8'hA5);
        check("lit_cnt1", bus.byte_cnt, 1);

        // Two bytes FF, D9
        frame(16, 10, 1, f, l);
        check("lit_FF", f, 8'hFF);
        check("lit_D9", l, 8'hD9);
        check("lit_cnt2", bus.byte_cnt, 2);

        // Abandoned partial byte, then the same byte leads the next frame
        frame(5, 10, 1, f, l);
        check("abandon_oe", bus.spi_miso_oe, 0);
        check("abandon_cnt", bus.byte_cnt, 0);
        wait_clks(10);
        frame(8, 10, 1, f, l);
        check("lit_3C", f, 8'h3C);

        // Randomised frames
        for (int k = 0; k < 20; k++) begin
            nb = $urandom_range(0, 24);
            hp = $urandom_range(8, 13);
            frame(nb, hp, 1, f, l);
            wait_clks($urandom_range(2, 12));
        end

        // Reset in the middle of a byte (bit_cnt = 4)
        bus.spi_cs_n = 1'b0;
        wait_clks(10);
        for (int b = 0; b < 4; b++) begin
            bus.spi_sck = 1'b1; wait_clks(10);
            bus.spi_sck = 1'b0; wait_clks(10);
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_oe", bus.spi_miso_oe, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_miso", bus.spi_miso, 0);
        check("arst_byte_cnt", bus.byte_cnt, 0);
        wait_clks(3);
        reset = 1'b0;
        for (int b = 0; b < 4; b++) begin
            wait_clks(8);
            bus.spi_sck = 1'b1; wait_clks(8);
            bus.spi_sck = 1'b0;
        end
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_cnt", bus.byte_cnt, 0);
        bus.spi_cs_n = 1'b1;
        wait_clks(20);
        frame(8, 10, 1, f, l);
        check("post_rst_cnt1", bus.byte_cnt, 1);

        // SCK toggling with CS high has no effect
        nrd = 0;
        for (int t = 0; t < 16; t++) begin
            bus.spi_sck = 1'b1;
            for (int c = 0; c < 4; c++) begin wait_clks(1); if (bus.spi_rd === 1'b1) nrd++; end
            bus.spi_sck = 1'b0;
            for (int c = 0; c < 4; c++) begin wait_clks(1); if (bus.spi_rd === 1'b1) nrd++; end
        end
        check("cs_hi_rd", nrd, 0);
        check("cs_hi_cnt", bus.byte_cnt, 1);
        check("cs_hi_miso", bus.spi_miso, 0);
        $display("sck toggled 16x with cs high: rd=%0d byte_cnt=%0d", nrd, bus.byte_cnt);

        // Fast master across a byte boundary -> sticky overrun
        frame(12, 3, 0, f, l);
        check("overrun_set", bus.overrun, 1);
        wait_clks(10);
        check("overrun_sticky", bus.overrun, 1);
        bus.spi_cs_n = 1'b0;
        wait_clks(10);
        check("overrun_clear", bus.overrun, 0);
        check("overrun_frame_busy", bus.busy, 1);
        bus.spi_cs_n = 1'b1;
        wait_clks(10);
        check("overrun_idle", bus.overrun, 0);
        $display("overrun sequence done: overrun=%0b", bus.overrun);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
